gemm_systolic_ctrl: RTL and testbench
=====================================

# gemm_systolic_ctrl

Job sequencer for the NumInputs x NumInputs GEMM systolic array. On a start command it reads operand A (row-banked) and B (column-banked) from SRAM with the diagonal skew the array expects, and drives the array's valid and accumulate-mux controls. It then drains the accumulated C tile eastward into the C SRAM and pulses done. It sits between the operand/result SRAM banks and the systolic array.

## Interface
- NumInputs, 4, array dimension N; number of SRAM lanes per operand
- InDataWidth, 8, signed operand width
- OutDataWidth, 32, signed accumulator width
- AddrWidth, 8, SRAM bank address width; also the width of k_len_i
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  job request, sampled in IDLE only
- k_len_i  in  AddrWidth  inner dimension K, sampled with start_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- sram_a_req_o / sram_b_req_o  out  [NumInputs]  per-lane read enable
- sram_a_addr_o / sram_b_addr_o  out  [NumInputs][AddrWidth]  per-lane read address
- sram_a_rdata_i / sram_b_rdata_i  in  [NumInputs][InDataWidth]  read data, 1-cycle latency
- arr_a_o / arr_b_o  out  [NumInputs][InDataWidth]  skewed operands to the array
- arr_valid_o  out  1  array valid_data
- arr_clear_o  out  1  one-cycle accumulator clear
- acc_mux_sel_o  out  2  00 = accumulate, 10 = shift east
- arr_c_i  in  [NumInputs][OutDataWidth]  array east-edge outputs
- sram_c_we_o  out  1  C write enable
- sram_c_addr_o  out  AddrWidth  C column address
- sram_c_wdata_o  out  [NumInputs][OutDataWidth]  C write data; lane r = row r

## Operation
- Memory layout:
  - A bank r holds A[r][k] at address k.
  - B bank c holds B[k][c] at address k.
  - C word at address j holds column j: lane r = C[r][j].
- States are IDLE, FEED, SETTLE, DRAIN and DONE.
- **IDLE**
  - start_i=1 with k_len_i≠0 latches K, pulses arr_clear_o in the next cycle and moves to FEED.
  - start_i=1 with k_len_i=0 moves directly to DONE; the array and SRAMs are not touched.
  - start_i outside IDLE is ignored.
- **FEED** lasts K+N-1 cycles, with step t = 0..K+N-2. For lane r:
  - sram_{a,b}_req_o[r] = (r ≤ t < r+K)
  - sram_{a,b}_addr_o[r] = t-r, and 0 when req is low
- **Operand path**
  - arr_a_o[r] / arr_b_o[r] are registered: rdata when the previous cycle's req[r] was 1, otherwise 0.
  - arr_valid_o is FEED delayed by one cycle.
- **SETTLE** lasts N cycles with acc_mux_sel_o=00 and no SRAM requests.
- **DRAIN** lasts N+1 cycles (d = 0..N) with acc_mux_sel_o=10 and arr_valid_o=0.
  - For d ≥ 1: sram_c_we_o=1, sram_c_addr_o = N-d, sram_c_wdata_o = arr_c_i sampled at cycle d-1.
- **DONE**: done_o=1 for one cycle, then return to IDLE.
- Arithmetic: the block does none on data and passes signed values unchanged. Step and counter widths cover K+N-1 for K up to 2^AddrWidth-1.

## Timing
- Reset values: every output is 0 and state is IDLE.
  - This includes acc_mux_sel_o=00, busy_o=0, done_o=0, all req and we signals 0, and all data and address buses 0.
- Cycle numbering, with start sampled at cycle 0 and K≠0:
  - arr_clear_o: cycle 1
  - FEED: cycles 1..K+N-1
  - arr_valid_o: cycles 2..K+N
  - SETTLE: cycles K+N..K+2N-1
  - DRAIN: cycles K+2N..K+3N
  - sram_c_we_o: cycles K+2N+1..K+3N
  - done_o: cycle K+3N+1
- With k_len_i=0, done_o pulses at cycle 1.
- Back-to-back jobs: start_i may be high in the cycle after done_o. A new job never begins in the DONE cycle.
- Reset mid-operation: all outputs return to reset values asynchronously.
  - No done_o is produced for the aborted job.
  - The pending C writes are lost.
- busy_o is high from cycle 1 through the done_o cycle, inclusive.

## Test plan
- **Reference GEMM:** N=4, K=4, A[i][k] = -(i·k), B[k][j] = j-1, behavioural SRAM models with 1-cycle latency.
  - Required: C[i][j] = -6·i·(j-1), e.g. C[3][3] = -36, C[2][0] = 12, C[0][*] = 0.
  - Required: done_o at cycle 17.
- **Skew check:** K=8.
  - Required at step t=5: lane 3 has req=1 and addr=2; at step t=10, lane 0 has req=0.
  - Required: arr_valid_o is high for exactly 11 cycles; done_o at cycle 21.
- **k_len_i=0:**
  - Required: done_o at cycle 1, busy_o high only in cycle 1, no req, we or clear activity.
- **Busy handling and back-to-back jobs:**
  - start_i held high during a job is ignored.
  - A second job started the cycle after done_o must get arr_clear_o, and its C equals its own product with no accumulation from job 1.
- **Mid-FEED reset:** assert rst_ni low at cycle 3.
  - Required: outputs go to 0 immediately with no done_o.
  - Required: a fresh job after reset produces the correct C.
- **Extreme operands:** all A = -128, all B = -128, K=4.
  - Required: every C entry = 65536; signedness is preserved through the operand path.

Source files
------------

// File: rtl/gemm_systolic_ctrl.sv
// gemm_systolic_ctrl
//   Job sequencer for an NumInputs x NumInputs GEMM systolic array.
//   On start it streams A (row-banked) and B (column-banked) out of SRAM
//   with the diagonal skew the array expects, drives the array's valid,
//   clear and accumulate-mux controls, then shifts the C tile eastward
//   out of the array into the C SRAM and pulses done.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, k_len_i       job request and inner dimension K (sampled in IDLE)
//   busy_o, done_o         job in progress / one-cycle completion pulse
//   sram_{a,b}_req_o       per-lane SRAM read enables
//   sram_{a,b}_addr_o      per-lane SRAM read addresses
//   sram_{a,b}_rdata_i     per-lane SRAM read data (1-cycle latency)
//   arr_a_o, arr_b_o       skewed operands into the array west/north edges
//   arr_valid_o            array valid_data
//   arr_clear_o            one-cycle accumulator clear
//   acc_mux_sel_o          00 = accumulate, 10 = shift east
//   arr_c_i                array east-edge accumulator outputs
//   sram_c_we_o            C SRAM write enable
//   sram_c_addr_o          C SRAM column address
//   sram_c_wdata_o         C SRAM write data, lane r = row r
module gemm_systolic_ctrl #(
    parameter int unsigned NumInputs    = 4,
    parameter int unsigned InDataWidth  = 8,
    parameter int unsigned OutDataWidth = 32,
    parameter int unsigned AddrWidth    = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      start_i,
    input  logic [AddrWidth-1:0]                      k_len_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [NumInputs-1:0]                      sram_a_req_o,
    output logic [NumInputs-1:0]                      sram_b_req_o,
    output logic [NumInputs-1:0][AddrWidth-1:0]       sram_a_addr_o,
    output logic [NumInputs-1:0][AddrWidth-1:0]       sram_b_addr_o,
    input  logic [NumInputs-1:0][InDataWidth-1:0]     sram_a_rdata_i,
    input  logic [NumInputs-1:0][InDataWidth-1:0]     sram_b_rdata_i,
    output logic [NumInputs-1:0][InDataWidth-1:0]     arr_a_o,
    output logic [NumInputs-1:0][InDataWidth-1:0]     arr_b_o,
    output logic                                      arr_valid_o,
    output logic                                      arr_clear_o,
    output logic [1:0]                                acc_mux_sel_o,
    input  logic [NumInputs-1:0][OutDataWidth-1:0]    arr_c_i,
    output logic                                      sram_c_we_o,
    output logic [AddrWidth-1:0]                      sram_c_addr_o,
    output logic [NumInputs-1:0][OutDataWidth-1:0]    sram_c_wdata_o
);

    // Step counter must reach K+N-2 for K up to 2^AddrWidth-1.
    localparam int unsigned CntW = AddrWidth + $clog2(NumInputs) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        SETTLE,
        DRAIN,
        DONE
    } state_e;

    state_e                                 state_q, state_d;
    logic [CntW-1:0]                        cnt_q, cnt_d;
    logic [AddrWidth-1:0]                   k_q;
    logic [NumInputs-1:0]                   req_q;
    logic                                   valid_q;
    logic                                   clear_q;
    logic [NumInputs-1:0][OutDataWidth-1:0] c_q;

    logic [CntW-1:0]                        k_ext;
    logic [CntW-1:0]                        feed_last;
    logic                                   start_job;
    logic [NumInputs-1:0]                   req;
    logic [NumInputs-1:0][AddrWidth-1:0]    addr;

    assign k_ext     = CntW'(k_q);
    assign feed_last = k_ext + CntW'(NumInputs) - CntW'(2);
    assign start_job = (state_q == IDLE) && start_i && (k_len_i != '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == IDLE) && start_i) begin
                k_q <= k_len_i;
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = (k_len_i == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (cnt_q == feed_last) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CntW'(NumInputs - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == CntW'(NumInputs)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- skewed SRAM requests ----------------
    // Lane r lags lane 0 by r steps: it reads k = t-r while r <= t < r+K.
    always_comb begin
        req  = '0;
        addr = '0;
        for (int unsigned r = 0; r < NumInputs; r++) begin
            if ((state_q == FEED) && (cnt_q >= CntW'(r)) && (cnt_q < CntW'(r) + k_ext)) begin
                req[r]  = 1'b1;
                addr[r] = AddrWidth'(cnt_q - CntW'(r));
            end
        end
    end

    assign sram_a_req_o  = req;
    assign sram_b_req_o  = req;
    assign sram_a_addr_o = addr;
    assign sram_b_addr_o = addr;

    // ---------------- operand path / array controls ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            valid_q <= 1'b0;
            clear_q <= 1'b0;
            c_q     <= '0;
        end else begin
            req_q   <= req;
            valid_q <= (state_q == FEED);
            clear_q <= start_job;
            if (state_q == DRAIN) begin
                c_q <= arr_c_i;
            end
        end
    end

    // Read data arrives one cycle after req; lanes without a read in the
    // previous cycle feed zeros so idle diagonals add nothing.
    always_comb begin
        arr_a_o = '0;
        arr_b_o = '0;
        for (int unsigned r = 0; r < NumInputs; r++) begin
            if (req_q[r]) begin
                arr_a_o[r] = sram_a_rdata_i[r];
                arr_b_o[r] = sram_b_rdata_i[r];
            end
        end
    end

    assign arr_valid_o   = valid_q;
    assign arr_clear_o   = clear_q;
    assign acc_mux_sel_o = (state_q == DRAIN) ? 2'b10 : 2'b00;

    // ---------------- C drain ----------------
    // Column N-d leaves the east edge at drain step d-1 and is written at d.
    assign sram_c_we_o    = (state_q == DRAIN) && (cnt_q != '0);
    assign sram_c_addr_o  = sram_c_we_o ? AddrWidth'(CntW'(NumInputs) - cnt_q) : '0;
    assign sram_c_wdata_o = sram_c_we_o ? c_q : '0;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_gemm_systolic_ctrl.sv
module tb_gemm_systolic_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 32;
    localparam int AW = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [AW-1:0]           k_len;
    logic                    busy, done;
    logic [N-1:0]            a_req, b_req;
    logic [N-1:0][AW-1:0]    a_addr, b_addr;
    logic [N-1:0][DW-1:0]    a_rdata, b_rdata;
    logic [N-1:0][DW-1:0]    arr_a, arr_b;
    logic                    arr_valid, arr_clear;
    logic [1:0]              sel;
    logic [N-1:0][OW-1:0]    arr_c;
    logic                    c_we;
    logic [AW-1:0]           c_addr;
    logic [N-1:0][OW-1:0]    c_wdata;

    gemm_systolic_ctrl #(
        .NumInputs   (N),
        .InDataWidth (DW),
        .OutDataWidth(OW),
        .AddrWidth   (AW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .k_len_i       (k_len),
        .busy_o        (busy),
        .done_o        (done),
        .sram_a_req_o  (a_req),
        .sram_b_req_o  (b_req),
        .sram_a_addr_o (a_addr),
        .sram_b_addr_o (b_addr),
        .sram_a_rdata_i(a_rdata),
        .sram_b_rdata_i(b_rdata),
        .arr_a_o       (arr_a),
        .arr_b_o       (arr_b),
        .arr_valid_o   (arr_valid),
        .arr_clear_o   (arr_clear),
        .acc_mux_sel_o (sel),
        .arr_c_i       (arr_c),
        .sram_c_we_o   (c_we),
        .sram_c_addr_o (c_addr),
        .sram_c_wdata_o(c_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM models (1-cycle latency) ----------------
    logic signed [DW-1:0] mem_a [N][256];
    logic signed [DW-1:0] mem_b [N][256];

    // Unrequested lanes return junk so operand masking is exercised.
    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            a_rdata[r] <= a_req[r] ? mem_a[r][a_addr[r]] : 8'h5A;
            b_rdata[r] <= b_req[r] ? mem_b[r][b_addr[r]] : 8'hA5;
        end
    end

    // ---------------- behavioural systolic array ----------------
    logic signed [DW-1:0] a_reg [N][N];
    logic signed [DW-1:0] b_reg [N][N];
    logic signed [OW-1:0] acc   [N][N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    logic signed [DW-1:0] ain, bin;
                    logic signed [OW-1:0] ax, bx;
                    if (j == 0) ain = $signed(arr_a[i]);
                    else        ain = a_reg[i][j-1];
                    if (i == 0) bin = $signed(arr_b[j]);
                    else        bin = b_reg[i-1][j];
                    ax = ain;
                    bx = bin;
                    a_reg[i][j] <= ain;
                    b_reg[i][j] <= bin;
                    if (arr_clear)         acc[i][j] <= '0;
                    else if (sel == 2'b10) acc[i][j] <= (j == 0) ? '0 : acc[i][j-1];
                    else                   acc[i][j] <= acc[i][j] + ax * bx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) arr_c[i] = acc[i][N-1];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int                    addr;
        logic [N-1:0][OW-1:0]  data;
    } sb_t;
    sb_t    sb_q[$];
    longint cap [N][N];

    always @(negedge clk) begin
        if (rst_n && c_we) begin
            check("c_write_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                sb_t e;
                e = sb_q.pop_front();
                check("c_addr", c_addr, e.addr);
                for (int r = 0; r < N; r++) begin
                    check($sformatf("c_data[%0d][%0d]", r, e.addr),
                          $signed(c_wdata[r]), $signed(e.data[r]));
                    cap[r][e.addr] = $signed(c_wdata[r]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic fill(input int k, input int pat);
        for (int r = 0; r < N; r++)
            for (int kk = 0; kk < k; kk++) begin
                case (pat)
                    0: begin
                        mem_a[r][kk] = DW'(-(r * kk));
                        mem_b[r][kk] = DW'(r - 1);
                    end
                    1: begin
                        mem_a[r][kk] = -8'sd128;
                        mem_b[r][kk] = -8'sd128;
                    end
                    default: begin
                        mem_a[r][kk] = DW'($urandom);
                        mem_b[r][kk] = DW'($urandom);
                    end
                endcase
            end
    endtask

    task automatic push_expected(input int k);
        longint c [N][N];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c[i][j] = 0;
                for (int kk = 0; kk < k; kk++)
                    c[i][j] += longint'(mem_a[i][kk]) * longint'(mem_b[j][kk]);
            end
        for (int d = 1; d <= N; d++) begin
            sb_t e;
            e.addr = N - d;
            for (int r = 0; r < N; r++) e.data[r] = OW'(c[r][N-d]);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, |{busy, done, a_req, b_req, a_addr, b_addr, arr_a, arr_b,
                      arr_valid, arr_clear, sel, c_we, c_addr, c_wdata}, 0);
    endtask

    typedef struct {
        int k;
        int pat;
        bit hold;      // keep start_i high for the whole job
        bit chained;   // begin in the cycle after the previous done_o
        int exp_done;
        int exp_valid;
    } vec_t;

    // Entered at the negedge of cycle 0 (or of the previous DONE cycle if chained).
    task automatic run_job(input vec_t v);
        int done_cyc = -1, clear_cnt = 0, clear_first = -1, valid_cnt = 0;
        int valid_first = -1, busy_cnt = 0, we_cnt = 0, req_cnt = 0, sel_cnt = 0;
        if (v.chained) @(negedge clk);
        fill(v.k, v.pat);
        if (v.k != 0) push_expected(v.k);
        k_len = AW'(v.k);
        start = 1'b1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (!v.hold) start = 1'b0;
            if (done) done_cyc = cyc;
            if (arr_clear) begin
                clear_cnt++;
                if (clear_first < 0) clear_first = cyc;
            end
            if (arr_valid) begin
                valid_cnt++;
                if (valid_first < 0) valid_first = cyc;
            end
            if (busy) busy_cnt++;
            if (c_we) we_cnt++;
            if (|a_req || |b_req) req_cnt++;
            if (sel == 2'b10) sel_cnt++;
            if (v.k == 8 && cyc == 6) begin
                check("skew_t5_lane3_req", a_req[3], 1);
                check("skew_t5_lane3_addr", a_addr[3], 2);
                check("skew_t5_lane3_breq", b_req[3], 1);
            end
            if (v.k == 8 && cyc == 11) check("skew_t10_lane0_req", a_req[0], 0);
        end
        check($sformatf("k%0d_done_cycle", v.k), done_cyc, v.exp_done);
        check($sformatf("k%0d_busy_cycles", v.k), busy_cnt, v.exp_done);
        check($sformatf("k%0d_valid_cycles", v.k), valid_cnt, v.exp_valid);
        check($sformatf("k%0d_clear_count", v.k), clear_cnt, (v.k != 0) ? 1 : 0);
        check($sformatf("k%0d_we_count", v.k), we_cnt, (v.k != 0) ? N : 0);
        check($sformatf("k%0d_req_cycles", v.k), req_cnt, (v.k != 0) ? v.k + N - 1 : 0);
        check($sformatf("k%0d_drain_sel_cycles", v.k), sel_cnt, (v.k != 0) ? N + 1 : 0);
        if (v.k != 0) begin
            check($sformatf("k%0d_clear_cycle", v.k), clear_first, 1);
            check($sformatf("k%0d_valid_first", v.k), valid_first, 2);
        end
        check($sformatf("k%0d_sb_empty", v.k), sb_q.size(), 0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{k: 4, pat: 0, hold: 0, chained: 0, exp_done: 17, exp_valid: 7};
        vecs[1] = '{k: 8, pat: 2, hold: 0, chained: 0, exp_done: 21, exp_valid: 11};
        vecs[2] = '{k: 0, pat: 2, hold: 0, chained: 0, exp_done: 1,  exp_valid: 0};
        vecs[3] = '{k: 4, pat: 2, hold: 1, chained: 0, exp_done: 17, exp_valid: 7};
        vecs[4] = '{k: 3, pat: 2, hold: 0, chained: 1, exp_done: 16, exp_valid: 6};
        vecs[5] = '{k: 4, pat: 1, hold: 0, chained: 0, exp_done: 17, exp_valid: 7};
        vecs[6] = '{k: 1, pat: 2, hold: 0, chained: 0, exp_done: 14, exp_valid: 4};

        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        for (int r = 0; r < N; r++)
            for (int a = 0; a < 256; a++) begin
                mem_a[r][a] = '0;
                mem_b[r][a] = '0;
            end
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_outputs_zero");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_job(vecs[i]);
            if (vecs[i].pat == 0) begin
                check("ref_c33", cap[3][3], -36);
                check("ref_c20", cap[2][0], 12);
                check("ref_c01", cap[0][1], 0);
            end
            if (vecs[i].pat == 1) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        check($sformatf("extreme_c%0d%0d", r, c), cap[r][c], 65536);
            end
            if (!vecs[i].hold) begin
                check("idle_after_done", busy, 1);
                @(negedge clk);
                check("idle_busy_low", busy, 0);
            end
        end

        // Mid-FEED reset: job started at cycle 0, reset asserted during cycle 3.
        fill(4, 2);
        k_len = AW'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        check("midreset_was_feeding", busy, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset_outputs_zero");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midreset_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) cap[r][c] = 99;
        run_job(vecs[0]);
        check("post_reset_c33", cap[3][3], -36);
        check("post_reset_c20", cap[2][0], 12);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
